p1_pool_write: RTL and testbench

Pooling-1 write stage. It consumes the conv1 output stream: 24×24 signed pixels per feature map, row-major, one pixel per valid beat. It applies 2×2 max pooling with stride 2 and writes the 12×12 result into the pooling-1 output memory at addresses 0–143. That memory is later scanned by the conv2 memory-read addresser. The block handles NUM_MAPS feature maps back to back, then raises a sticky `done`.

---
 rtl/p1_pool_write.sv | 96 +++++++++
 tb/tb_p1_pool_write.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/p1_pool_write.sv
// Pooling-1 write stage: 2x2/stride-2 max pool of the conv1
// stream, written into the pooling-1 memory one map after another.
module p1_pool_write #(
  parameter int DATA_W   = 16,
  parameter int IN_DIM   = 24,
  parameter int NUM_MAPS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     mem_we,
  output logic [7:0]               mem_addr,
  output logic signed [DATA_W-1:0] mem_wdata,
  output logic [1:0]               map_sel,
  output logic                     done
);

  localparam int OUT_DIM = IN_DIM / 2;
  localparam int CW      = $clog2(IN_DIM);

  logic [CW-1:0]            col;
  logic [CW-1:0]            row;
  logic [1:0]               map;
  logic signed [DATA_W-1:0] pair;
  logic signed [DATA_W-1:0] linebuf [OUT_DIM];

  logic                     accept;
  logic                     last_col;
  logic                     last_row;
  logic                     last_map;
  logic                     wr_now;
  logic [CW-2:0]            half;
  logic signed [DATA_W-1:0] pm;
  logic signed [DATA_W-1:0] pool;
  logic [7:0]               addr;

  // Beat qualification, pooling maxima and write address
  always_comb begin
    accept   = enable & in_valid & ~done;
    last_col = (col == CW'(IN_DIM - 1));
    last_row = (row == CW'(IN_DIM - 1));
    last_map = (map == 2'(NUM_MAPS - 1));
    half     = col[CW-1:1];
    pm       = (in_data > pair) ? in_data : pair;
    pool     = (linebuf[half] > pm) ? linebuf[half] : pm;
    addr     = 8'(row[CW-1:1]) * 8'(OUT_DIM) + 8'(half);
    wr_now   = accept & row[0] & col[0];
  end

  // Pixel position counters: col, then row, then map
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      map <= '0;
    end else if (accept) begin
      col <= last_col ? '0 : col + 1'b1;
      if (last_col)
        row <= last_row ? '0 : row + 1'b1;
      if (last_col && last_row)
        map <= last_map ? '0 : map + 1'b1;
    end
  end

  // Horizontal pair capture and even-row line buffer; overwritten
  // before every read, so they need no reset
  always_ff @(posedge clk) begin
    if (accept && !col[0])
      pair <= in_data;
    if (accept && col[0] && !row[0])
      linebuf[half] <= pm;
  end

  // Registered memory write port and sticky done
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      map_sel   <= '0;
      done      <= 1'b0;
    end else begin
      mem_we <= wr_now;
      if (wr_now) begin
        mem_addr  <= addr;
        mem_wdata <= pool;
        map_sel   <= map;
      end
      if (accept && last_col && last_row && last_map)
        done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_p1_pool_write.sv
// Bench for p1_pool_write: a pixel-image model predicts every
// output each cycle; directed literals pin key pooled values.
module tb_p1_pool_write;

  localparam int NM = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               mem_we;
  logic [7:0]         mem_addr;
  logic signed [15:0] mem_wdata;
  logic [1:0]         map_sel;
  logic               done;

  p1_pool_write #(
    .DATA_W(16), .IN_DIM(24), .NUM_MAPS(NM)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .map_sel(map_sel), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int nwr = 0;
  bit armed = 0;

  logic signed [15:0] got [NM][144];

  // model state
  logic signed [15:0] img [24][24];
  int beats = 0;
  bit e_we = 0;
  int e_addr = 0;
  int e_data = 0;
  int e_map = 0;
  bit e_done = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // model: watches the input stream at each edge
  initial begin
    int m, p, r, c, v;
    forever begin
      @(posedge clk);
      e_we = 0;
      if (reset) begin
        beats = 0; e_addr = 0; e_data = 0;
        e_map = 0; e_done = 0;
      end else if (enable && in_valid && !e_done) begin
        m = beats / 576;
        p = beats % 576;
        r = p / 24;
        c = p % 24;
        img[r][c] = in_data;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          v = mx(mx(int'(img[r-1][c-1]), int'(img[r-1][c])),
                 mx(int'(img[r][c-1]), int'(img[r][c])));
          e_we = 1;
          e_addr = (r / 2) * 12 + c / 2;
          e_data = v;
          e_map = m;
          if (m == NM - 1 && p == 575) e_done = 1;
        end
        beats++;
      end
    end
  end

  // compare process: every cycle once out of first reset
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("mem_we", int'(mem_we), int'(e_we));
        chk("mem_addr", int'(mem_addr), e_addr);
        chk("mem_wdata", int'(mem_wdata), e_data);
        chk("map_sel", int'(map_sel), e_map);
        chk("done", int'(done), int'(e_done));
        if (mem_we === 1'b1) begin
          nwr++;
          if (map_sel < NM && mem_addr < 144)
            got[map_sel][mem_addr] = mem_wdata;
        end
      end
    end
  end

  task automatic drive(input bit v, input bit e,
                       input logic signed [15:0] d);
    @(negedge clk);
    in_valid = v;
    enable = e;
    in_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 16'sd0);
  endtask

  task automatic do_reset(input bit v);
    @(negedge clk);
    reset = 1;
    in_valid = v;
    enable = 1;
    in_data = 16'sd77;
    @(negedge clk);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    chk("rst_map", int'(map_sel), 0);
    chk("rst_done", int'(done), 0);
    reset = 0;
    in_valid = 0;
  endtask

  function automatic logic signed [15:0] ramp(input int m,
                                              input int p);
    return 16'(m * 1000 + p);
  endfunction

  function automatic int ramp_pool(input int m, input int k);
    return m * 1000 + (2 * (k / 12) + 1) * 24 + 2 * (k % 12) + 1;
  endfunction

  initial begin
    int n0, errs;
    // reset
    do_reset(0);
    armed = 1;
    idle(2);

    // ramp, one map
    n0 = nwr;
    for (int p = 0; p < 576; p++) drive(1, 1, ramp(0, p));
    idle(3);
    chk("ramp_writes", nwr - n0, 144);
    chk("ramp_a0", int'(got[0][0]), 25);
    chk("ramp_a143", int'(got[0][143]), 575);
    chk("ramp_done_low", int'(done), 0);
    do_reset(0);

    // signed compare: -100 with -3 at (1,0)
    for (int p = 0; p < 48; p++)
      drive(1, 1, (p == 24) ? -16'sd3 : -16'sd100);
    idle(3);
    chk("sgn_a0", int'(got[0][0]), -3);
    chk("sgn_a1", int'(got[0][1]), -100);
    chk("sgn_a11", int'(got[0][11]), -100);
    do_reset(0);

    // signed compare: 0x7FFF at (0,1)
    for (int p = 0; p < 48; p++)
      drive(1, 1, (p == 1) ? 16'sh7FFF : -16'sd100);
    idle(3);
    chk("max_a0", int'(got[0][0]), 32767);
    chk("max_a1", int'(got[0][1]), -100);
    do_reset(0);

    // ramp with gaps and an enable-low stretch mid-row
    n0 = nwr;
    for (int p = 0; p < 576; p++) begin
      while ($urandom_range(0, 2) == 0)
        drive(0, 1, 16'sd999);
      if (p == 100)
        for (int i = 0; i < 10; i++) drive(1, 0, 16'sh7000);
      drive(1, 1, ramp(0, p));
    end
    idle(3);
    chk("gap_writes", nwr - n0, 144);
    errs = 0;
    for (int k = 0; k < 144; k++)
      if (int'(got[0][k]) != ramp_pool(0, k)) errs++;
    chk("gap_table", errs, 0);
    do_reset(0);

    // 300 beats, then reset colliding with a valid beat
    for (int p = 0; p < 300; p++) drive(1, 1, 16'sd5000);
    do_reset(1);

    // three maps back to back
    n0 = nwr;
    for (int m = 0; m < NM; m++)
      for (int p = 0; p < 576; p++) drive(1, 1, ramp(m, p));
    idle(3);
    chk("maps_writes", nwr - n0, 432);
    chk("maps_m0a0", int'(got[0][0]), 25);
    chk("maps_m1a0", int'(got[1][0]), 1025);
    chk("maps_m2a143", int'(got[2][143]), 2575);
    chk("maps_done", int'(done), 1);
    chk("maps_sel", int'(map_sel), 2);
    errs = 0;
    for (int m = 0; m < NM; m++)
      for (int k = 0; k < 144; k++)
        if (int'(got[m][k]) != ramp_pool(m, k)) errs++;
    chk("maps_table", errs, 0);

    // post-done beats are ignored
    n0 = nwr;
    for (int p = 0; p < 50; p++) drive(1, 1, 16'sd9000);
    idle(3);
    chk("post_writes", nwr - n0, 0);
    chk("post_done", int'(done), 1);
    chk("post_addr", int'(mem_addr), 143);
    chk("post_wdata", int'(mem_wdata), 2575);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
